// File: rtl/pwm_motor_ctrl_multi.sv
// pwm_motor_ctrl_multi: N-channel PWM driver for L298-style bridges.
// One shared carrier counter; each channel ramps its applied duty toward a
// commanded target once per carrier period, coasts through a dead time when
// reversing, and latches a filtered overcurrent fault until released.
module pwm_motor_ctrl_multi #(
  parameter int NCH          = 2,
  parameter int CW           = 19,
  parameter int PERIOD       = 250000,
  parameter int RAMP_STEP    = 625,
  parameter int DEAD_PERIODS = 4,
  parameter int OC_FILTER    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*CW-1:0] duty_cmd,
  input  logic [NCH-1:0]    dir_cmd,
  input  logic              cmd_load,
  input  logic [NCH-1:0]    oc_in,
  input  logic              oc_clear,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    in_a,
  output logic [NCH-1:0]    in_b,
  output logic [NCH-1:0]    fault,
  output logic              period_tick
);

  localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
  localparam logic [CW-1:0] PERIOD_M1 = CW'(PERIOD - 1);
  localparam logic [CW-1:0] STEP_C    = CW'(RAMP_STEP);
  localparam int            OCW       = $clog2(OC_FILTER + 1);
  localparam logic [OCW-1:0] OC_LIMIT = OCW'(OC_FILTER);
  localparam int            DCW       = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;
  localparam logic [DCW-1:0] DEAD_INIT = DCW'(DEAD_PERIODS);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_RAMP_DOWN,
    ST_DEAD,
    ST_FAULT
  } state_t;

  logic [CW-1:0] counter_reg;

  // The last count of the carrier is the period boundary for every channel.
  assign period_tick = (counter_reg == PERIOD_M1);

  // Shared carrier counter, 0..PERIOD-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_reg <= '0;
    end else if (period_tick) begin
      counter_reg <= '0;
    end else begin
      counter_reg <= counter_reg + CW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0]  cmd_duty;
      logic [CW-1:0]  tgt_duty_reg;
      logic           tgt_dir_reg;
      logic           oc_meta_reg;
      logic           oc_sync_reg;
      logic [OCW-1:0] oc_cnt_reg;
      logic           oc_trip;
      state_t         state_reg, state_next;
      logic [CW-1:0]  duty_app_reg, duty_next;
      logic           cur_dir_reg, dir_next;
      logic [DCW-1:0] dead_cnt_reg, dead_next;
      logic [CW-1:0]  step_toward, step_down;
      logic           drive;
      logic           pwm_next, in_a_next, in_b_next, fault_next;
      logic           pwm_reg, in_a_reg, in_b_reg, fault_reg;

      assign cmd_duty = duty_cmd[gi*CW +: CW];
      assign oc_trip  = (oc_cnt_reg == OC_LIMIT);

      // Target registers: duty clamped to a full period on load.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tgt_duty_reg <= '0;
          tgt_dir_reg  <= 1'b1;
        end else if (cmd_load) begin
          tgt_duty_reg <= (cmd_duty > PERIOD_C) ? PERIOD_C : cmd_duty;
          tgt_dir_reg  <= dir_cmd[gi];
        end
      end

      // Two-flop synchronizer and consecutive-high filter for the sense line.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          oc_meta_reg <= 1'b0;
          oc_sync_reg <= 1'b0;
          oc_cnt_reg  <= '0;
        end else begin
          oc_meta_reg <= oc_in[gi];
          oc_sync_reg <= oc_meta_reg;
          if (!oc_sync_reg) begin
            oc_cnt_reg <= '0;
          end else if (oc_cnt_reg != OC_LIMIT) begin
            oc_cnt_reg <= oc_cnt_reg + OCW'(1);
          end
        end
      end

      // Channel state, applied duty and direction registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg    <= ST_RUN;
          duty_app_reg <= '0;
          cur_dir_reg  <= 1'b1;
          dead_cnt_reg <= '0;
        end else begin
          state_reg    <= state_next;
          duty_app_reg <= duty_next;
          cur_dir_reg  <= dir_next;
          dead_cnt_reg <= dead_next;
        end
      end

      // Next-state logic; the fault trip overrides every state and command.
      always_comb begin
        state_next = state_reg;
        duty_next  = duty_app_reg;
        dir_next   = cur_dir_reg;
        dead_next  = dead_cnt_reg;

        if (tgt_duty_reg > duty_app_reg) begin
          step_toward = ((tgt_duty_reg - duty_app_reg) > STEP_C) ? duty_app_reg + STEP_C : tgt_duty_reg;
        end else begin
          step_toward = ((duty_app_reg - tgt_duty_reg) > STEP_C) ? duty_app_reg - STEP_C : tgt_duty_reg;
        end
        step_down = (duty_app_reg > STEP_C) ? duty_app_reg - STEP_C : '0;

        if (oc_trip) begin
          state_next = ST_FAULT;
          duty_next  = '0;
        end else begin
          case (state_reg)
            ST_RUN, ST_RAMP_DOWN: begin
              if (period_tick) begin
                if (tgt_dir_reg == cur_dir_reg) begin
                  state_next = ST_RUN;
                  duty_next  = step_toward;
                end else if (step_down == '0) begin
                  state_next = ST_DEAD;
                  duty_next  = '0;
                  dead_next  = DEAD_INIT;
                end else begin
                  state_next = ST_RAMP_DOWN;
                  duty_next  = step_down;
                end
              end
            end
            ST_DEAD: begin
              if (period_tick) begin
                if (dead_cnt_reg <= DCW'(1)) begin
                  state_next = ST_RUN;
                  dir_next   = tgt_dir_reg;
                  dead_next  = '0;
                end else begin
                  dead_next = dead_cnt_reg - DCW'(1);
                end
              end
            end
            ST_FAULT: begin
              if (oc_clear && !oc_sync_reg) begin
                state_next = ST_RUN;
                duty_next  = '0;
              end
            end
            default: state_next = ST_RUN;
          endcase
        end

        drive      = (state_next == ST_RUN) || (state_next == ST_RAMP_DOWN);
        pwm_next   = drive && (counter_reg < duty_app_reg);
        in_a_next  = drive && dir_next;
        in_b_next  = drive && !dir_next;
        fault_next = (state_next == ST_FAULT);
      end

      // Registered pin drivers; reset forces every pin low immediately.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pwm_reg   <= 1'b0;
          in_a_reg  <= 1'b0;
          in_b_reg  <= 1'b0;
          fault_reg <= 1'b0;
        end else begin
          pwm_reg   <= pwm_next;
          in_a_reg  <= in_a_next;
          in_b_reg  <= in_b_next;
          fault_reg <= fault_next;
        end
      end

      assign pwm_out[gi] = pwm_reg;
      assign in_a[gi]    = in_a_reg;
      assign in_b[gi]    = in_b_reg;
      assign fault[gi]   = fault_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_motor_ctrl_multi.sv
// Bench for pwm_motor_ctrl_multi: reference model predicts every cycle's pins,
// a monitor compares them; directed scenarios add period-level measurements.
module tb_pwm_motor_ctrl_multi;
  localparam int NCH = 2, CW = 8, PERIOD = 100, RAMP_STEP = 10, DEAD_PERIODS = 2, OC_FILTER = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*CW-1:0] duty_cmd = '0;
  logic [NCH-1:0]    dir_cmd = '1;
  logic              cmd_load = 1'b0;
  logic [NCH-1:0]    oc_in = '0;
  logic              oc_clear = 1'b0;
  logic [NCH-1:0]    pwm_out, in_a, in_b, fault;
  logic              period_tick;

  always #5 clk = ~clk;

  pwm_motor_ctrl_multi #(
    .NCH(NCH), .CW(CW), .PERIOD(PERIOD), .RAMP_STEP(RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS), .OC_FILTER(OC_FILTER)
  ) dut (
    .clk(clk), .reset(reset), .duty_cmd(duty_cmd), .dir_cmd(dir_cmd), .cmd_load(cmd_load),
    .oc_in(oc_in), .oc_clear(oc_clear), .pwm_out(pwm_out), .in_a(in_a), .in_b(in_b),
    .fault(fault), .period_tick(period_tick)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // Reference model: per channel applied duty, direction, remaining coast
  // periods, fault flag, and the sense line seen through two sample delays.
  int m_cnt;
  int m_tgt[NCH];
  bit m_tdir[NCH];
  int m_duty[NCH];
  bit m_dir[NCH];
  int m_coast[NCH];
  bit m_flt[NCH];
  bit m_s1[NCH];
  bit m_s2[NCH];
  int m_run[NCH];

  task automatic model_reset();
    m_cnt = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_tgt[ch] = 0; m_tdir[ch] = 1'b1; m_duty[ch] = 0; m_dir[ch] = 1'b1;
      m_coast[ch] = 0; m_flt[ch] = 1'b0; m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_run[ch] = 0;
    end
  endtask

  function automatic int toward(input int from, input int to);
    if (to > from) return (to - from > RAMP_STEP) ? from + RAMP_STEP : to;
    return (from - to > RAMP_STEP) ? from - RAMP_STEP : to;
  endfunction

  // Advance the model across one rising edge; returns the pins expected after it.
  task automatic model_step(output logic [8:0] e);
    logic [NCH-1:0] p, a, b, f;
    int c;
    bit tick;
    p = '0; a = '0; b = '0; f = '0;
    if (reset) begin
      model_reset();
      e = '0;
      return;
    end
    c = m_cnt;
    tick = (c == PERIOD - 1);
    for (int ch = 0; ch < NCH; ch++) begin
      bit synced, nf, drive;
      int duty_pre;
      synced = m_s2[ch];
      duty_pre = m_duty[ch];
      nf = (m_run[ch] >= OC_FILTER) || (m_flt[ch] && !(oc_clear && !synced));
      if (nf) begin
        m_duty[ch] = 0;
        m_coast[ch] = 0;
      end else if (m_flt[ch]) begin
        m_duty[ch] = 0;
      end else if (tick) begin
        if (m_coast[ch] > 0) begin
          m_coast[ch]--;
          if (m_coast[ch] == 0) m_dir[ch] = m_tdir[ch];
        end else if (m_tdir[ch] == m_dir[ch]) begin
          m_duty[ch] = toward(m_duty[ch], m_tgt[ch]);
        end else begin
          m_duty[ch] = (m_duty[ch] > RAMP_STEP) ? m_duty[ch] - RAMP_STEP : 0;
          if (m_duty[ch] == 0) m_coast[ch] = DEAD_PERIODS;
        end
      end
      m_flt[ch] = nf;
      drive = !nf && (m_coast[ch] == 0);
      p[ch] = drive && (c < duty_pre);
      a[ch] = drive && m_dir[ch];
      b[ch] = drive && !m_dir[ch];
      f[ch] = nf;
      m_run[ch] = synced ? ((m_run[ch] + 1 > OC_FILTER) ? OC_FILTER : m_run[ch] + 1) : 0;
      m_s2[ch] = m_s1[ch];
      m_s1[ch] = oc_in[ch];
    end
    if (cmd_load) begin
      for (int ch = 0; ch < NCH; ch++) begin
        int d;
        d = int'(duty_cmd[ch*CW +: CW]);
        m_tgt[ch] = (d > PERIOD) ? PERIOD : d;
        m_tdir[ch] = dir_cmd[ch];
      end
    end
    m_cnt = tick ? 0 : c + 1;
    e = {p, a, b, f, (m_cnt == PERIOD - 1)};
  endtask

  // Producer: push the model's expectation for every edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      model_step(e);
      exp_q.push_back(e);
    end
  end

  // Monitor: compare the pins just after each edge against the oldest expectation.
  initial begin
    logic [8:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      got = {pwm_out, in_a, in_b, fault, period_tick};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got %b", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t pwm/in_a/in_b/fault/tick got %b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                   $time, got[8:7], got[6:5], got[4:3], got[2:1], got[0], e[8:7], e[6:5], e[4:3], e[2:1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("check %s: %0d", name, got);
    end
  endtask

  task automatic load(input int d0, input int d1, input bit dir0, input bit dir1);
    @(negedge clk);
    duty_cmd = {CW'(d1), CW'(d0)};
    dir_cmd = {dir1, dir0};
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    $display("load d0=%0d d1=%0d dir=%b%b", d0, d1, dir1, dir0);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[ch]);
    end
  endtask

  // Return at a negedge where period_tick is high (bounded).
  task automatic wait_tick(input string name);
    int k;
    for (k = 0; k < 2 * PERIOD; k++) begin
      if (period_tick) break;
      @(negedge clk);
    end
    if (k == 2 * PERIOD) begin
      checks++;
      errors++;
      $display("FAIL %s: period_tick not seen in %0d clks", name, 2 * PERIOD);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, cnt0, cnt1, lat;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({pwm_out, in_a, in_b, fault, period_tick}), 0);
    reset = 1'b0;

    // Ramp 0 -> 50 in steps of 10, one step per period.
    load(50, 0, 1'b1, 1'b1);
    wait_tick("t1_tick");
    for (int s = 1; s <= 5; s++) begin
      count_high(0, PERIOD, hi);
      check($sformatf("t1_ramp_%0d", s), hi, 10 * s);
    end
    count_high(0, PERIOD, hi);
    check("t1_steady_50", hi, 50);
    check("t1_in_a0", int'(in_a[0]), 1);
    check("t1_in_b0", int'(in_b[0]), 0);

    // Full, zero, and clamped duty.
    load(100, 0, 1'b1, 1'b1);
    repeat (7 * PERIOD) @(negedge clk);
    count_high(0, PERIOD, hi);
    check("t2_duty100", hi, 100);
    load(0, 0, 1'b1, 1'b1);
    repeat (12 * PERIOD) @(negedge clk);
    count_high(0, PERIOD, hi);
    check("t2_duty0", hi, 0);
    load(200, 0, 1'b1, 1'b1);
    repeat (12 * PERIOD) @(negedge clk);
    count_high(0, PERIOD, hi);
    check("t2_duty200_clamped", hi, 100);

    // Asynchronous reset while pwm is high.
    @(negedge clk);
    check("t6_pwm_high_before_reset", int'(pwm_out[0]), 1);
    #3 reset = 1'b1;
    #1 check("t6_async_reset_outputs", int'({pwm_out, in_a, in_b, fault}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Load coincident with a tick takes effect one period later.
    @(negedge clk);
    wait_tick("t6_tick");
    duty_cmd = {CW'(0), CW'(10)};
    dir_cmd = 2'b11;
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    count_high(0, PERIOD, hi);
    check("t6_load_on_tick_first", hi, 0);
    count_high(0, PERIOD, hi);
    check("t6_load_on_tick_second", hi, 10);

    // Reversal: ramp down, coast two periods, ramp up reversed.
    load(30, 60, 1'b1, 1'b1);
    repeat (12 * PERIOD) @(negedge clk);
    load(30, 60, 1'b0, 1'b1);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 9 * PERIOD; k++) begin
      @(negedge clk);
      if (!in_a[0] && !in_b[0]) cnt0++;
      if (in_a[1] && !in_b[1]) cnt1++;
    end
    check("t3_coast_clks", cnt0, 2 * PERIOD);
    check("t3_ch1_fwd_clks", cnt1, 9 * PERIOD);
    check("t3_in_b0", int'(in_b[0]), 1);
    check("t3_in_a0", int'(in_a[0]), 0);
    count_high(0, PERIOD, hi);
    check("t3_rev_duty30", hi, 30);

    // Overcurrent filter: short pulse ignored, long pulse trips.
    @(negedge clk);
    oc_in = 2'b10;
    repeat (3) @(negedge clk);
    oc_in = 2'b00;
    cnt1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt1 += int'(fault[1]);
    end
    check("t4_short_pulse_no_fault", cnt1, 0);
    oc_in = 2'b10;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fault[1]) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat > 7) begin
      errors++;
      $display("FAIL t4_fault_latency: got %0d clks expected <= 7", lat);
    end else begin
      $display("check t4_fault_latency: %0d", lat);
    end
    cnt0 = 0;
    cnt1 = 0;
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      cnt1 += int'(pwm_out[1]) + int'(in_a[1]) + int'(in_b[1]);
      cnt0 += int'(fault[1]);
    end
    check("t4_ch1_pins_low", cnt1, 0);
    check("t4_fault_held", cnt0, PERIOD);
    check("t4_ch0_runs_on", hi, 30);

    // Release only once the sense line is low.
    oc_clear = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_clear_with_oc_high", int'(fault[1]), 1);
    oc_in = 2'b00;
    repeat (5) @(negedge clk);
    oc_clear = 1'b0;
    check("t5_released", int'(fault[1]), 0);
    repeat (9 * PERIOD) @(negedge clk);
    count_high(1, PERIOD, hi);
    check("t5_ch1_reramped", hi, 60);

    // Randomized commands, sense pulses and clear strobes.
    begin
      int oc_left[NCH];
      for (int ch = 0; ch < NCH; ch++) oc_left[ch] = 0;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        cmd_load = ($urandom_range(0, 149) == 0);
        if (cmd_load) begin
          duty_cmd = {CW'($urandom_range(0, 130)), CW'($urandom_range(0, 130))};
          dir_cmd = NCH'($urandom_range(0, 3));
          $display("rand load t=%0t duty=%0d/%0d dir=%b", $time, duty_cmd[CW +: CW], duty_cmd[0 +: CW], dir_cmd);
        end
        for (int ch = 0; ch < NCH; ch++) begin
          if (oc_left[ch] > 0) begin
            oc_left[ch]--;
            oc_in[ch] = 1'b1;
          end else begin
            oc_in[ch] = 1'b0;
            if ($urandom_range(0, 399) == 0) oc_left[ch] = int'($urandom_range(1, 9));
          end
        end
        oc_clear = ($urandom_range(0, 15) == 0);
      end
      cmd_load = 1'b0;
      oc_in = '0;
      oc_clear = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
